extensor_16_32_reg: RTL and testbench

Registered 16-to-32-bit immediate extender for the 16-bit processor datapath. It takes a 16-bit immediate (sinal16) and a mode select, and produces a 32-bit extended value (sinal32) one clock later. Modes are sign-extend, zero-extend, upper-load and sign-extend-shift-left-1. It sits between instruction decode and the ALU operand mux.

---
 rtl/extensor_pkg.sv | 14 +
 rtl/extensor_core.sv | 28 ++
 rtl/extensor_16_32_reg.sv | 73 +++++++
 tb/tb_extensor_16_32_reg.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/extensor_pkg.sv
// rtl/extensor_pkg.sv - mode encodings and width defaults for the immediate extender
package extensor_pkg;

   localparam int IN_W_DEF  = 16;
   localparam int OUT_W_DEF = 32;

   typedef logic [1:0] modo_t;

   localparam modo_t MODO_SIGN      = 2'b00;
   localparam modo_t MODO_ZERO      = 2'b01;
   localparam modo_t MODO_UPPER     = 2'b10;
   localparam modo_t MODO_SIGN_SHL1 = 2'b11;

endpackage

// File: rtl/extensor_core.sv
// rtl/extensor_core.sv - combinational immediate extension (sign, zero, upper, sign<<1)
module extensor_core
   import extensor_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic [1:0]       modo,
   input  logic [IN_W-1:0]  sinal16,
   output logic [OUT_W-1:0] valor
);

   logic [OUT_W-1:0] sext;

   // Select the extension selected by modo; sign<<1 drops the top bit of the sign-extended value
   always_comb begin
      sext  = {{(OUT_W-IN_W){sinal16[IN_W-1]}}, sinal16};
      valor = '0;
      case (modo_t'(modo))
         MODO_SIGN:      valor = sext;
         MODO_ZERO:      valor = {{(OUT_W-IN_W){1'b0}}, sinal16};
         MODO_UPPER:     valor = {sinal16, {(OUT_W-IN_W){1'b0}}};
         MODO_SIGN_SHL1: valor = {sext[OUT_W-2:0], 1'b0};
         default:        valor = '0;
      endcase
   end

endmodule

// File: rtl/extensor_16_32_reg.sv
// rtl/extensor_16_32_reg.sv - registered 16-to-32 immediate extender; EXTENSOR_PIPE2_EN adds a second stage
module extensor_16_32_reg
   import extensor_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             valid_in,
   input  logic [1:0]       modo,
   input  logic [IN_W-1:0]  sinal16,
   output logic [OUT_W-1:0] sinal32,
   output logic             valid_out
);

   logic [OUT_W-1:0] valor;

   logic [OUT_W-1:0] s1_data_d, s1_data_q;
   logic             s1_valid_d, s1_valid_q;

   extensor_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
      .modo    (modo),
      .sinal16 (sinal16),
      .valor   (valor)
   );

   // Stage 1 next state: capture only on valid_in so X on idle inputs never reaches the register
   always_comb begin
      s1_valid_d = valid_in;
      s1_data_d  = valid_in ? valor : s1_data_q;
   end

   // Stage 1 register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_data_q  <= '0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_data_q  <= s1_data_d;
         s1_valid_q <= s1_valid_d;
      end
   end

`ifdef EXTENSOR_PIPE2_EN
   logic [OUT_W-1:0] s2_data_d, s2_data_q;
   logic             s2_valid_d, s2_valid_q;

   // Stage 2 next state: forward fresh results, hold data across bubbles
   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
   end

   // Stage 2 register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s2_data_q  <= '0;
         s2_valid_q <= 1'b0;
      end else begin
         s2_data_q  <= s2_data_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   assign sinal32   = s2_data_q;
   assign valid_out = s2_valid_q;
`else
   assign sinal32   = s1_data_q;
   assign valid_out = s1_valid_q;
`endif

endmodule

// File: tb/tb_extensor_16_32_reg.sv
// tb/tb_extensor_16_32_reg.sv - directed bench for extensor_16_32_reg (honours EXTENSOR_PIPE2_EN)
module tb_extensor_16_32_reg;

`ifdef EXTENSOR_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [1:0]  modo;
   logic [15:0] sinal16;
   logic [31:0] sinal32;
   logic        valid_out;

   int checks   = 0;
   int failures = 0;

   extensor_16_32_reg dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .valid_in  (valid_in),
      .modo      (modo),
      .sinal16   (sinal16),
      .sinal32   (sinal32),
      .valid_out (valid_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one valid vector, idle the inputs with X, check the result after LAT edges and the hold one edge later
   task automatic run_vec(input string tag, input logic [1:0] m, input logic [15:0] d, input logic [31:0] exp);
      @(negedge clock);
      valid_in = 1'b1;
      modo     = m;
      sinal16  = d;
      @(posedge clock);
      #1;
      valid_in = 1'b0;
      modo     = 2'bxx;
      sinal16  = 16'hxxxx;
      repeat (LAT - 1) begin
         @(posedge clock);
         #1;
      end
      chk({tag, "_data"}, sinal32, exp);
      chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
      @(posedge clock);
      #1;
      chk({tag, "_hold_data"}, sinal32, exp);
      chk({tag, "_hold_valid"}, {31'd0, valid_out}, 32'd0);
   endtask

   logic [1:0]  bm [3];
   logic [15:0] bd [3];
   logic [31:0] be [3];

   initial begin
      reset_n  = 1'b0;
      valid_in = 1'b0;
      modo     = 2'b00;
      sinal16  = 16'h0000;
      #12;
      chk("reset_data", sinal32, 32'h0);
      chk("reset_valid", {31'd0, valid_out}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      run_vec("sign_pos",   2'b00, 16'h5555, 32'h00005555);
      run_vec("sign_neg",   2'b00, 16'hFD55, 32'hFFFFFD55);
      run_vec("zero",       2'b01, 16'hFD55, 32'h0000FD55);
      run_vec("upper",      2'b10, 16'hFD55, 32'hFD550000);
      run_vec("shl1_8000",  2'b11, 16'h8000, 32'hFFFF0000);
      run_vec("shl1_4000",  2'b11, 16'h4000, 32'h00008000);
      run_vec("sign_8000",  2'b00, 16'h8000, 32'hFFFF8000);
      run_vec("sign_7fff",  2'b00, 16'h7FFF, 32'h00007FFF);
      run_vec("shl1_ffff",  2'b11, 16'hFFFF, 32'hFFFFFFFE);

      // Back-to-back valid inputs followed by a bubble
      bm[0] = 2'b00; bd[0] = 16'h1234; be[0] = 32'h00001234;
      bm[1] = 2'b10; bd[1] = 16'hABCD; be[1] = 32'hABCD0000;
      bm[2] = 2'b11; bd[2] = 16'hC001; be[2] = 32'hFFFF8002;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i < 3) begin
            valid_in = 1'b1;
            modo     = bm[i];
            sinal16  = bd[i];
         end else begin
            valid_in = 1'b0;
            modo     = 2'bxx;
            sinal16  = 16'hxxxx;
         end
         @(posedge clock);
         #1;
         begin
            int j;
            j = i - LAT + 1;
            if (j >= 0) begin
               chk($sformatf("b2b_valid_%0d", j), {31'd0, valid_out}, (j < 3) ? 32'd1 : 32'd0);
               chk($sformatf("b2b_data_%0d", j), sinal32, be[(j < 3) ? j : 2]);
            end
         end
      end

      // Asynchronous reset mid-stream after a valid result
      @(negedge clock);
      valid_in = 1'b1;
      modo     = 2'b01;
      sinal16  = 16'hBEEF;
      repeat (LAT) @(posedge clock);
      #1;
      chk("pre_reset_data", sinal32, 32'h0000BEEF);
      chk("pre_reset_valid", {31'd0, valid_out}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_data", sinal32, 32'h0);
      chk("async_reset_valid", {31'd0, valid_out}, 32'd0);
      valid_in = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;

      // First capture after release
      run_vec("post_reset", 2'b00, 16'h0001, 32'h00000001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
